// File: rtl/data_mem_responder.sv
// Multi-channel memory responder: each channel runs an IDLE/BUSY/RESP FSM with fixed latency.
// Optional backdoor write port enabled by defining DATA_MEM_BACKDOOR_EN.
module data_mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_request,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_request,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready
`ifdef DATA_MEM_BACKDOOR_EN
    ,
    input  logic                                   bd_write_enable,
    input  logic [ADDR_BITS-1:0]                   bd_address,
    input  logic [DATA_BITS-1:0]                   bd_data
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state      [NUM_CHANNELS];
    state_t                state_next [NUM_CHANNELS];
    logic                  op_write      [NUM_CHANNELS];
    logic                  op_write_next [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  addr       [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  addr_next  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]  wdata      [NUM_CHANNELS];
    logic [DATA_BITS-1:0]  wdata_next [NUM_CHANNELS];
    logic [3:0]            count      [NUM_CHANNELS];
    logic [3:0]            count_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] active;
    logic [NUM_CHANNELS-1:0] commit;
    logic [NUM_CHANNELS-1:0] load_read;

    logic [DATA_BITS-1:0]  mem [DEPTH];

    // A read wins over a simultaneous write in IDLE; the write simply stays pending.
    always_comb begin
        active    = '0;
        commit    = '0;
        load_read = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_next[c]    = state[c];
            op_write_next[c] = op_write[c];
            addr_next[c]     = addr[c];
            wdata_next[c]    = wdata[c];
            count_next[c]    = count[c];
            active[c]        = op_write[c] ? mem_write_request[c] : mem_read_request[c];
            case (state[c])
                IDLE: begin
                    if (mem_read_request[c]) begin
                        op_write_next[c] = 1'b0;
                        addr_next[c]     = mem_read_address[c];
                        count_next[c]    = LOAD;
                        state_next[c]    = BUSY;
                    end else if (mem_write_request[c]) begin
                        op_write_next[c] = 1'b1;
                        addr_next[c]     = mem_write_address[c];
                        wdata_next[c]    = mem_write_data[c];
                        count_next[c]    = LOAD;
                        state_next[c]    = BUSY;
                    end
                end
                BUSY: begin
                    if (!active[c]) begin
                        count_next[c] = 4'd0;
                        state_next[c] = IDLE;
                    end else if (count[c] == 4'd0) begin
                        state_next[c] = RESP;
                        commit[c]     = op_write[c];
                        load_read[c]  = !op_write[c];
                    end else begin
                        count_next[c] = count[c] - 4'd1;
                    end
                end
                RESP: begin
                    if (!active[c]) begin
                        state_next[c] = IDLE;
                    end
                end
                default: state_next[c] = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_read_ready[c]  = (state[c] == RESP) && !op_write[c];
            mem_write_ready[c] = (state[c] == RESP) && op_write[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]         <= IDLE;
                op_write[c]      <= 1'b0;
                addr[c]          <= '0;
                wdata[c]         <= '0;
                count[c]         <= 4'd0;
                mem_read_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]    <= state_next[c];
                op_write[c] <= op_write_next[c];
                addr[c]     <= addr_next[c];
                wdata[c]    <= wdata_next[c];
                count[c]    <= count_next[c];
                if (load_read[c]) begin
                    mem_read_data[c] <= mem[addr[c]];
                end
            end
        end
    end

    // Later assignments win, so channels are applied highest-first to let channel 0 take priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
`ifdef DATA_MEM_BACKDOOR_EN
            if (bd_write_enable) begin
                mem[bd_address] <= bd_data;
            end
`endif
            for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
                if (commit[c]) begin
                    mem[addr[c]] <= wdata[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic vs. an array model.
// Backdoor scenario runs only when DATA_MEM_BACKDOOR_EN is defined.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic            clk;
    logic            reset;
    logic [3:0]      read_req;
    logic [3:0][7:0] read_addr;
    logic [3:0]      read_ready;
    logic [3:0][7:0] read_data;
    logic [3:0]      write_req;
    logic [3:0][7:0] write_addr;
    logic [3:0][7:0] write_data;
    logic [3:0]      write_ready;
`ifdef DATA_MEM_BACKDOOR_EN
    logic            bd_we;
    logic [7:0]      bd_addr;
    logic [7:0]      bd_dat;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model_mem [256];

    data_mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_read_request(read_req),
        .mem_read_address(read_addr),
        .mem_read_ready(read_ready),
        .mem_read_data(read_data),
        .mem_write_request(write_req),
        .mem_write_address(write_addr),
        .mem_write_data(write_data),
        .mem_write_ready(write_ready)
`ifdef DATA_MEM_BACKDOOR_EN
        ,
        .bd_write_enable(bd_we),
        .bd_address(bd_addr),
        .bd_data(bd_dat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    endtask

    // Runs one transaction on an idle channel; scrambles address/data after acceptance.
    task automatic run_txn(input int ch, input bit wr, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rdata, output bit drop_ok);
        lat = -1;
        rdata = 8'h00;
        if (wr) begin
            write_req[ch] = 1'b1; write_addr[ch] = a; write_data[ch] = d;
        end else begin
            read_req[ch] = 1'b1; read_addr[ch] = a;
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                read_addr[ch] = 8'($urandom); write_addr[ch] = 8'($urandom);
                write_data[ch] = 8'($urandom);
            end
            if (wr ? write_ready[ch] : read_ready[ch]) begin
                lat = n - 1;
                rdata = read_data[ch];
                break;
            end
        end
        read_req[ch] = 1'b0;
        write_req[ch] = 1'b0;
        tick();
        drop_ok = (read_ready[ch] == 1'b0) && (write_ready[ch] == 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (read_ready !== 4'h0 || write_ready !== 4'h0 || read_data !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_outputs rr=%h wr=%h data=%h required 0/0/0",
                         read_ready, write_ready, read_data);
            end
        end
        read_req[0] = 1'b1;
        read_addr[0] = 8'h00;
        tick();
        checks++;
        if (read_ready !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_holds_idle rr=%h required 0", read_ready);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (read_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_early rr0=%b required 0", read_ready[0]);
        end
        tick();
        checks++;
        if (read_ready[0] !== 1'b1 || read_data[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_first_edge rr0=%b data=%h required 1/00",
                     read_ready[0], read_data[0]);
        end
        read_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] rd; bit dok;
        run_txn(0, 1'b1, 8'h10, 8'h5A, lat, rd, dok);
        model_mem[8'h10] = 8'h5A;
        checks++;
        if (lat != LAT || !dok) begin
            errors++;
            $display("[TB] FAIL write_latency got=%0d drop=%0b required %0d/1", lat, dok, LAT);
        end
        run_txn(0, 1'b0, 8'h10, 8'h00, lat, rd, dok);
        checks++;
        if (lat != LAT || rd !== 8'h5A || !dok) begin
            errors++;
            $display("[TB] FAIL read_back lat=%0d data=%h drop=%0b required %0d/5a/1", lat, rd, dok, LAT);
        end
    endtask

    task automatic test_parallel_read();
        int lat; logic [7:0] rd; bit dok;
        logic [7:0] pre [4];
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            run_txn(0, 1'b1, 8'(i), pre[i], lat, rd, dok);
            model_mem[i] = pre[i];
        end
        for (int c = 0; c < 4; c++) begin
            read_req[c] = 1'b1; read_addr[c] = 8'(c);
        end
        tick();
        tick();
        checks++;
        if (read_ready !== 4'h0) begin
            errors++;
            $display("[TB] FAIL parallel_early rr=%h required 0", read_ready);
        end
        tick();
        checks++;
        if (read_ready !== 4'hF) begin
            errors++;
            $display("[TB] FAIL parallel_ready rr=%h required f", read_ready);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (read_data[c] !== model_mem[c]) begin
                errors++;
                $display("[TB] FAIL parallel_data ch=%0d got=%h required %h", c, read_data[c], model_mem[c]);
            end
        end
        read_req = 4'h0;
        tick();
    endtask

    task automatic test_same_addr_write();
        int lat; logic [7:0] rd; bit dok;
        write_req[1] = 1'b1; write_addr[1] = 8'h20; write_data[1] = 8'hAA;
        write_req[2] = 1'b1; write_addr[2] = 8'h20; write_data[2] = 8'hBB;
        repeat (LAT + 1) tick();
        checks++;
        if (write_ready !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL collide_ready wr=%b required 0110", write_ready);
        end
        write_req = 4'h0;
        tick();
        model_mem[8'h20] = 8'hAA;
        run_txn(3, 1'b0, 8'h20, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== 8'hAA || lat != LAT) begin
            errors++;
            $display("[TB] FAIL collide_winner data=%h lat=%0d required aa/%0d", rd, lat, LAT);
        end
    endtask

    task automatic test_hold_and_priority();
        int lat; logic [7:0] rd; bit dok;
        run_txn(0, 1'b1, 8'h40, 8'h3C, lat, rd, dok);
        model_mem[8'h40] = 8'h3C;
        read_req[2] = 1'b1; read_addr[2] = 8'h40;
        repeat (LAT + 1) tick();
        read_addr[2] = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (read_ready[2] !== 1'b1 || read_data[2] !== 8'h3C) begin
                errors++;
                $display("[TB] FAIL hold_stable k=%0d rr=%b data=%h required 1/3c", k, read_ready[2], read_data[2]);
            end
        end
        read_req[2] = 1'b0;
        tick();
        checks++;
        if (read_ready[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_drop rr=%b required 0", read_ready[2]);
        end
        read_req[2] = 1'b1; read_addr[2] = 8'h40;
        tick();
        tick();
        checks++;
        if (read_ready[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reissue_early rr=%b required 0", read_ready[2]);
        end
        tick();
        checks++;
        if (read_ready[2] !== 1'b1 || read_data[2] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL reissue_ready rr=%b data=%h required 1/3c", read_ready[2], read_data[2]);
        end
        read_req[2] = 1'b0;
        tick();
        // Read and write together: the read goes first, the write follows after an idle cycle.
        read_req[0] = 1'b1; read_addr[0] = 8'h40;
        write_req[0] = 1'b1; write_addr[0] = 8'h41; write_data[0] = 8'h9E;
        repeat (LAT + 1) tick();
        checks++;
        if (read_ready[0] !== 1'b1 || write_ready[0] !== 1'b0 || read_data[0] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL rw_read_first rr=%b wr=%b data=%h required 1/0/3c",
                     read_ready[0], write_ready[0], read_data[0]);
        end
        read_req[0] = 1'b0;
        repeat (LAT + 2) tick();
        checks++;
        if (write_ready[0] !== 1'b1 || read_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rw_write_pending wr=%b rr=%b required 1/0", write_ready[0], read_ready[0]);
        end
        write_req[0] = 1'b0;
        tick();
        model_mem[8'h41] = 8'h9E;
        run_txn(1, 1'b0, 8'h41, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== 8'h9E) begin
            errors++;
            $display("[TB] FAIL rw_write_value data=%h required 9e", rd);
        end
    endtask

    task automatic test_abandon();
        int lat; logic [7:0] rd; bit dok; bit seen;
        run_txn(0, 1'b1, 8'h50, 8'h0F, lat, rd, dok);
        model_mem[8'h50] = 8'h0F;
        write_req[1] = 1'b1; write_addr[1] = 8'h50; write_data[1] = 8'hC3;
        tick();
        write_req[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (write_ready[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL abandon_ready seen=1 required 0");
        end
        run_txn(2, 1'b0, 8'h50, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== model_mem[8'h50]) begin
            errors++;
            $display("[TB] FAIL abandon_word data=%h required %h", rd, model_mem[8'h50]);
        end
        write_req[0] = 1'b1; write_addr[0] = 8'h60; write_data[0] = 8'h99;
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if (read_ready !== 4'h0 || write_ready !== 4'h0 || read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_busy rr=%h wr=%h data=%h required 0/0/0", read_ready, write_ready, read_data);
        end
        write_req = 4'h0;
        tick();
        reset = 1'b1;
        clear_model();
        tick();
        run_txn(0, 1'b0, 8'h60, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== 8'h00 || lat != LAT) begin
            errors++;
            $display("[TB] FAIL reset_target data=%h lat=%0d required 00/%0d", rd, lat, LAT);
        end
        run_txn(1, 1'b0, 8'h10, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_clears data=%h required 00", rd);
        end
    endtask

    task automatic test_random_single();
        int lat; logic [7:0] rd; bit dok;
        for (int it = 0; it < 40; it++) begin
            int ch; bit wr; logic [7:0] a; logic [7:0] d;
            ch = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15)) + 8'h80;
            d = 8'($urandom);
            run_txn(ch, wr, a, d, lat, rd, dok);
            checks++;
            if (lat != LAT || !dok) begin
                errors++;
                $display("[TB] FAIL rand_latency it=%0d lat=%0d drop=%0b required %0d/1", it, lat, dok, LAT);
            end
            if (wr) begin
                model_mem[a] = d;
            end else begin
                checks++;
                if (rd !== model_mem[a]) begin
                    errors++;
                    $display("[TB] FAIL rand_read it=%0d addr=%h got=%h required %h", it, a, rd, model_mem[a]);
                end
            end
        end
    endtask

    // All channels start together on a tiny address window to force collisions.
    task automatic test_random_concurrent();
        int lat; logic [7:0] rd; bit dok;
        for (int r = 0; r < 12; r++) begin
            int op [4]; logic [7:0] ca [4]; logic [7:0] cd [4]; logic [7:0] er [4];
            logic [3:0] exp_r; logic [3:0] exp_w;
            exp_r = 4'h0; exp_w = 4'h0;
            for (int c = 0; c < 4; c++) begin
                op[c] = $urandom_range(0, 2);
                ca[c] = 8'h30 + 8'($urandom_range(0, 3));
                cd[c] = 8'($urandom);
                er[c] = model_mem[ca[c]];
                if (op[c] == 1) begin
                    read_req[c] = 1'b1; read_addr[c] = ca[c]; exp_r[c] = 1'b1;
                end else if (op[c] == 2) begin
                    write_req[c] = 1'b1; write_addr[c] = ca[c]; write_data[c] = cd[c]; exp_w[c] = 1'b1;
                end
            end
            repeat (LAT + 1) tick();
            checks++;
            if (read_ready !== exp_r || write_ready !== exp_w) begin
                errors++;
                $display("[TB] FAIL conc_ready r=%0d rr=%b wr=%b required %b/%b", r, read_ready, write_ready, exp_r, exp_w);
            end
            for (int c = 0; c < 4; c++) begin
                if (op[c] == 1) begin
                    checks++;
                    if (read_data[c] !== er[c]) begin
                        errors++;
                        $display("[TB] FAIL conc_read r=%0d ch=%0d got=%h required %h", r, c, read_data[c], er[c]);
                    end
                end
            end
            for (int c = 3; c >= 0; c--) begin
                if (op[c] == 2) model_mem[ca[c]] = cd[c];
            end
            read_req = 4'h0;
            write_req = 4'h0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            run_txn(i, 1'b0, 8'h30 + 8'(i), 8'h00, lat, rd, dok);
            checks++;
            if (rd !== model_mem[8'h30 + i]) begin
                errors++;
                $display("[TB] FAIL conc_final addr=%h got=%h required %h", 8'h30 + i, rd, model_mem[8'h30 + i]);
            end
        end
    endtask

`ifdef DATA_MEM_BACKDOOR_EN
    task automatic test_backdoor();
        int lat; logic [7:0] rd; bit dok;
        bd_we = 1'b1; bd_addr = 8'hFF; bd_dat = 8'h77;
        tick();
        bd_we = 1'b0;
        model_mem[8'hFF] = 8'h77;
        run_txn(3, 1'b0, 8'hFF, 8'h00, lat, rd, dok);
        checks++;
        if (rd !== 8'h77) begin
            errors++;
            $display("[TB] FAIL backdoor_read got=%h required 77", rd);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        read_req = '0; read_addr = '0;
        write_req = '0; write_addr = '0; write_data = '0;
`ifdef DATA_MEM_BACKDOOR_EN
        bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
`endif
        clear_model();
        test_reset();
        test_write_read();
        test_parallel_read();
        test_same_addr_write();
        test_hold_and_priority();
        test_abandon();
        test_random_single();
        test_random_concurrent();
`ifdef DATA_MEM_BACKDOOR_EN
        test_backdoor();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
